// File: rtl/operand_prep_stage.sv
// Operand front-end for the (x+y)*(y-x) datapath: a small (x, y) FIFO feeding a registered sum/diff stage.
// Optional build macro OPERAND_PREP_SAT_EN: saturate out_sum high on overflow and out_diff to zero on underflow.
module operand_prep_stage #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [WIDTH-1:0] out_diff,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem_x [DEPTH];
    logic [WIDTH-1:0] r_mem_y [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_sum;
    logic [WIDTH-1:0] r_out_diff;

    logic             w_in_ready;
    logic             w_push;
    logic             w_load;
    logic [WIDTH-1:0] w_head_x;
    logic [WIDTH-1:0] w_head_y;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;

    // in_ready depends on the registered count only, so out_ready never reaches it combinationally.
    assign w_in_ready = (r_count != CNT_W'(DEPTH));
    assign w_push     = in_valid && w_in_ready;
    assign w_load     = (r_count != '0) && (!r_out_valid || out_ready);

    assign w_head_x = r_mem_x[r_rptr];
    assign w_head_y = r_mem_y[r_rptr];

`ifdef OPERAND_PREP_SAT_EN
    logic [WIDTH:0] w_sum_full;
    assign w_sum_full = {1'b0, w_head_x} + {1'b0, w_head_y};
    assign w_sum      = w_sum_full[WIDTH] ? '1 : w_sum_full[WIDTH-1:0];
    assign w_diff     = (w_head_x > w_head_y) ? '0 : (w_head_y - w_head_x);
`else
    assign w_sum  = w_head_x + w_head_y;
    assign w_diff = w_head_y - w_head_x;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_x[i] <= '0;
                r_mem_y[i] <= '0;
            end
            r_wptr <= '0;
        end else if (w_push) begin
            r_mem_x[r_wptr] <= in_x;
            r_mem_y[r_wptr] <= in_y;
            r_wptr          <= r_wptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rptr      <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_diff  <= '0;
        end else if (w_load) begin
            r_rptr      <= r_rptr + 1'b1;
            r_out_valid <= 1'b1;
            r_out_sum   <= w_sum;
            r_out_diff  <= w_diff;
        end else if (r_out_valid && out_ready) begin
            // Drained with nothing buffered: drop valid, keep the last data visible.
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_diff  = r_out_diff;
    assign count     = r_count;

endmodule

// File: tb/tb_operand_prep_stage.sv
// Self-checking bench for operand_prep_stage: directed scenarios plus randomized traffic against a queue-based model.
module tb_operand_prep_stage;
    localparam int W  = 16;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_x = '0;
    logic [W-1:0]  in_y = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_sum;
    logic [W-1:0]  out_diff;
    logic [CW-1:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    operand_prep_stage #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_diff(out_diff), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
    } pair_t;

    // Model: FIFO contents as a queue plus the presented result.
    pair_t        mq[$];
    logic         m_valid = 1'b0;
    logic [W-1:0] m_sum = '0;
    logic [W-1:0] m_diff = '0;

    function automatic logic [W-1:0] f_sum(input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned s;
        s = int'(x) + int'(y);
`ifdef OPERAND_PREP_SAT_EN
        if (s >= (32'd1 << W)) return '1;
`endif
        return W'(s);
    endfunction

    function automatic logic [W-1:0] f_diff(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef OPERAND_PREP_SAT_EN
        if (x > y) return '0;
`endif
        return y - x;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_valid = 1'b0;
        m_sum   = '0;
        m_diff  = '0;
    endfunction

    // Advance one rising edge; model decisions use the state and inputs present before the edge.
    task automatic tick();
        bit    p_push;
        bit    p_load;
        pair_t p;
        p_push = in_valid && (mq.size() != D);
        p_load = (mq.size() != 0) && (!m_valid || out_ready);
        p.x = in_x;
        p.y = in_y;
        @(posedge clk);
        if (p_load) begin
            pair_t h;
            h = mq.pop_front();
            m_valid = 1'b1;
            m_sum   = f_sum(h.x, h.y);
            m_diff  = f_diff(h.x, h.y);
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        if (p_push) mq.push_back(p);
        #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (out_sum !== '0 || out_diff !== '0) begin n_bad++; $display("FAIL reset_data got sum=%h diff=%h want 0/0", out_sum, out_diff); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        in_valid = 1'b1; in_x = 16'd10; in_y = 16'd20;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_no_bypass got %0b want 0", out_valid); end
        n_cmp++; if (count !== CW'(1)) begin n_bad++; $display("FAIL basic_count1 got %0d want 1", count); end
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %0b want 1", out_valid); end
        n_cmp++; if (out_sum !== 16'd30 || out_diff !== 16'd10) begin n_bad++; $display("FAIL basic_data got %0d/%0d want 30/10", out_sum, out_diff); end
        n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL basic_count0 got %0d want 0", count); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_drain got %0b want 0", out_valid); end
        $display("test_basic done");
    endtask

    task automatic test_wrap();
        logic [W-1:0] exp_diff;
        logic [W-1:0] exp_sum;
`ifdef OPERAND_PREP_SAT_EN
        exp_diff = 16'h0000; exp_sum = 16'hFFFF;
`else
        exp_diff = 16'hFFF6; exp_sum = 16'h0001;
`endif
        out_ready = 1'b1;
        in_valid = 1'b1; in_x = 16'd20; in_y = 16'd10;
        tick();
        in_x = 16'hFFFF; in_y = 16'd2;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_diff !== exp_diff || out_sum !== 16'd30) begin n_bad++; $display("FAIL wrap_diff got v=%0b sum=%h diff=%h want 1/001e/%h", out_valid, out_sum, out_diff, exp_diff); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_sum !== exp_sum || out_diff !== 16'h0003) begin n_bad++; $display("FAIL wrap_sum got v=%0b sum=%h diff=%h want 1/%h/0003", out_valid, out_sum, out_diff, exp_sum); end
        tick();
        $display("test_wrap done");
    endtask

    task automatic test_fill();
        int accepted = 0;
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1; in_x = W'(i); in_y = W'(i);
            if (in_ready) accepted++;
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (accepted != 5) begin n_bad++; $display("FAIL fill_accepted got %0d want 5", accepted); end
        n_cmp++; if (in_ready !== 1'b0 || count !== CW'(4)) begin n_bad++; $display("FAIL fill_full got ready=%0b count=%0d want 0/4", in_ready, count); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_sum !== 16'd2) begin n_bad++; $display("FAIL fill_hold got v=%0b sum=%0d want 1/2", out_valid, out_sum); end
        end
        out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_sum !== W'(2 * (j + 1))) begin n_bad++; $display("FAIL drain_order got v=%0b sum=%0d want 1/%0d", out_valid, out_sum, 2 * (j + 1)); end
            tick();
            if (j == 0) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL drain_in_ready got %0b want 1", in_ready); end
            end
        end
        n_cmp++; if (out_valid !== 1'b0 || count !== '0) begin n_bad++; $display("FAIL drain_empty got v=%0b count=%0d want 0/0", out_valid, count); end
        $display("test_fill done");
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            in_valid = 1'b1; in_x = W'(i); in_y = W'(2 * i);
            tick();
            n_cmp++; if (count > CW'(1)) begin n_bad++; $display("FAIL stream_count got %0d want <=1", count); end
            if (i >= 2) begin
                n_cmp++; if (out_valid !== 1'b1 || out_sum !== W'(3 * (i - 1)) || out_diff !== W'(i - 1)) begin
                    n_bad++; $display("FAIL stream_data got v=%0b %0d/%0d want 1/%0d/%0d", out_valid, out_sum, out_diff, 3 * (i - 1), i - 1);
                end
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_sum !== 16'd60 || out_diff !== 16'd20) begin n_bad++; $display("FAIL stream_last got v=%0b %0d/%0d want 1/60/20", out_valid, out_sum, out_diff); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_drain got %0b want 0", out_valid); end
        $display("test_stream done");
    endtask

    task automatic test_full_pushpop();
        logic [W-1:0] exp_q[$];
        int           cyc = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_x = W'($urandom); in_y = W'($urandom);
            exp_q.push_back(f_sum(in_x, in_y));
            tick();
        end
        in_valid = 1'b1; in_x = 16'd100; in_y = 16'd300;
        out_ready = 1'b1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL pp_full_ready got %0b want 0", in_ready); end
        exp_q.push_back(16'd400);
        while ((out_valid || in_valid || count != '0) && cyc < 40) begin
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_bad++; $display("FAIL pp_dup got sum=%h want none", out_sum); end
                else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    if (out_sum !== e) begin n_bad++; $display("FAIL pp_order got sum=%h want %h", out_sum, e); end
                end
            end
            if (cyc == 1) begin
                n_cmp++; if (in_ready !== 1'b1 || count !== CW'(3)) begin n_bad++; $display("FAIL pp_after_pop got ready=%0b count=%0d want 1/3", in_ready, count); end
            end
            if (cyc >= 1) in_valid = in_ready ? in_valid : 1'b0;
            tick();
            if (cyc == 1) in_valid = 1'b0;
            cyc++;
        end
        n_cmp++; if (exp_q.size() != 0 || cyc >= 40) begin n_bad++; $display("FAIL pp_loss got %0d left cyc=%0d want 0", exp_q.size(), cyc); end
        $display("test_full_pushpop done");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_x = W'(i + 7); in_y = W'(i + 50);
            tick();
        end
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_cmp++; if (out_valid !== 1'b0 || count !== '0) begin n_bad++; $display("FAIL midrst_clear got v=%0b count=%0d want 0/0", out_valid, count); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got %0b want 1", in_ready); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0 || count !== '0) begin n_bad++; $display("FAIL midrst_stale got v=%0b count=%0d want 0/0", out_valid, count); end
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            in_x = W'($urandom);
            in_y = W'($urandom);
            n_cmp++; if (in_ready !== (mq.size() != D)) begin n_bad++; $display("FAIL rnd_in_ready cyc %0d got %0b want %0b", c, in_ready, mq.size() != D); end
            tick();
            n_cmp++; if (out_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", c, out_valid, m_valid); end
            n_cmp++; if (out_sum !== m_sum || out_diff !== m_diff) begin n_bad++; $display("FAIL rnd_data cyc %0d got %h/%h want %h/%h", c, out_sum, out_diff, m_sum, m_diff); end
            n_cmp++; if (count !== CW'(mq.size())) begin n_bad++; $display("FAIL rnd_count cyc %0d got %0d want %0d", c, count, mq.size()); end
        end
        in_valid = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_fill();
        test_stream();
        test_full_pushpop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
